// File: rtl/halflife_pkg.sv
// Shared types and constants for the half-life counter sequencer.
// Provides the FSM state enum, default widths and the minimum period.
package halflife_pkg;

    localparam int N_DEF      = 4;
    localparam int PW_DEF     = 16;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        DONE
    } state_t;

    // Button events after priority arbitration (at most one bit set)
    typedef struct packed {
        logic clr;
        logic start;
        logic pause;
        logic ext;
    } ev_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse.
// Ports: clk, rst (sync, active-high), pin (async in), pulse (1-cycle out).
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    // pulse rises 3 clocks after pin rises; holding pin gives one pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= pin;
            s2    <= s1;
            s3    <= s2;
            pulse <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/halflife_ctrl.sv
// Sequencer for the half-life up/down counter: buttons -> counter controls.
// In: clk, rst, start/pause/clear/ext_btn, preset[N], period[PW], cnt[N].
// Out: cnt_rst, cnt_load, cnt_in[N], cnt_up, cnt_down, busy, done.
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_btn,
    input  logic          pause_btn,
    input  logic          clear_btn,
    input  logic          ext_btn,
    input  logic [N-1:0]  preset,
    input  logic [PW-1:0] period,
    input  logic [N-1:0]  cnt,
    output logic          cnt_rst,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_in,
    output logic          cnt_up,
    output logic          cnt_down,
    output logic          busy,
    output logic          done
);

    logic raw_clr;
    logic raw_start;
    logic raw_pause;
    logic raw_ext;

    btn_sync_edge u_clr (
        .clk(clk), .rst(rst), .pin(clear_btn), .pulse(raw_clr)
    );
    btn_sync_edge u_start (
        .clk(clk), .rst(rst), .pin(start_btn), .pulse(raw_start)
    );
    btn_sync_edge u_pause (
        .clk(clk), .rst(rst), .pin(pause_btn), .pulse(raw_pause)
    );
    btn_sync_edge u_ext (
        .clk(clk), .rst(rst), .pin(ext_btn), .pulse(raw_ext)
    );

    ev_t ev;

    always_comb begin
        ev.clr   = raw_clr;
        ev.start = raw_start & ~raw_clr;
        ev.pause = raw_pause & ~raw_clr & ~raw_start;
        ev.ext   = raw_ext & ~raw_clr & ~raw_start & ~raw_pause;
    end

    state_t        state;
    state_t        state_d;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_d;
    logic [PW-1:0] reload;
    logic [N-1:0]  cnt_in_d;
    logic          rst_d;
    logic          load_d;
    logic          up_d;
    logic          down_d;
    logic          inflight;
    logic          can_up;

    assign reload = (period < PW'(MIN_PERIOD)) ?
                    PW'(MIN_PERIOD - 1) : period - PW'(1);

    // a pulse already on the wire means cnt is stale this cycle
    assign inflight = cnt_up | cnt_down;
    assign can_up   = (cnt != '1) && !inflight;

    always_comb begin
        state_d  = state;
        pre_d    = pre;
        cnt_in_d = cnt_in;
        rst_d    = 1'b0;
        load_d   = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
        unique case (1'b1)
            ev.clr: begin
                rst_d   = 1'b1;
                state_d = IDLE;
            end
            ev.start: begin
                cnt_in_d = preset;
                load_d   = 1'b1;
                state_d  = LOAD;
            end
            default: begin
                unique case (state)
                    LOAD: begin
                        pre_d   = reload;
                        state_d = RUN;
                    end
                    RUN: begin
                        // the pause cycle itself freezes the prescaler
                        if (ev.pause) begin
                            state_d = PAUSED;
                        end else begin
                            if (pre == '0) begin
                                pre_d = reload;
                                // tick colliding with ext drops both
                                if (!ev.ext) begin
                                    down_d = (cnt != '0) && !inflight;
                                end
                            end else begin
                                pre_d = pre - PW'(1);
                                up_d  = ev.ext && can_up;
                            end
                            if (cnt == '0 && !inflight && !up_d) begin
                                state_d = DONE;
                            end
                        end
                    end
                    PAUSED: begin
                        if (ev.pause) begin
                            state_d = RUN;
                        end else begin
                            up_d = ev.ext && can_up;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            cnt_in   <= '0;
            cnt_rst  <= 1'b0;
            cnt_load <= 1'b0;
            cnt_up   <= 1'b0;
            cnt_down <= 1'b0;
        end else begin
            state    <= state_d;
            pre      <= pre_d;
            cnt_in   <= cnt_in_d;
            cnt_rst  <= rst_d;
            cnt_load <= load_d;
            cnt_up   <= up_d;
            cnt_down <= down_d;
        end
    end

    assign busy = (state == LOAD) || (state == RUN) || (state == PAUSED);
    assign done = (state == DONE);

endmodule

// File: tb/tb_halflife_ctrl.sv
// Directed bench for halflife_ctrl with a behavioural up/down counter.
// Pulse cycles are logged at negedge and compared to hand-derived cycles.
module tb_halflife_ctrl;
    import halflife_pkg::*;

    localparam int N  = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_btn;
    logic          pause_btn;
    logic          clear_btn;
    logic          ext_btn;
    logic [N-1:0]  preset;
    logic [PW-1:0] period;
    logic [N-1:0]  cnt;
    logic          cnt_rst;
    logic          cnt_load;
    logic [N-1:0]  cnt_in;
    logic          cnt_up;
    logic          cnt_down;
    logic          busy;
    logic          done;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;
    int multi  = 0;
    int lq[$];
    int dq[$];
    int uq[$];
    int rq[$];

    always #5 clk = ~clk;

    halflife_ctrl #(.N(N), .PW(PW)) dut (
        .clk(clk), .rst(rst),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .clear_btn(clear_btn), .ext_btn(ext_btn),
        .preset(preset), .period(period), .cnt(cnt),
        .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_in(cnt_in),
        .cnt_up(cnt_up), .cnt_down(cnt_down),
        .busy(busy), .done(done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // downstream counter
    always @(posedge clk) begin
        if (rst || cnt_rst) cnt <= '0;
        else if (cnt_load)  cnt <= cnt_in;
        else if (cnt_up)    cnt <= cnt + 1'b1;
        else if (cnt_down)  cnt <= cnt - 1'b1;
    end

    always @(negedge clk) begin
        if (cnt_load) lq.push_back(cyc);
        if (cnt_down) dq.push_back(cyc);
        if (cnt_up)   uq.push_back(cyc);
        if (cnt_rst)  rq.push_back(cyc);
        if (int'(cnt_rst) + int'(cnt_load) + int'(cnt_up)
            + int'(cnt_down) > 1) multi++;
    end

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // m = {clear, start, pause, ext}; pin raised in the current cycle
    task automatic press(input logic [3:0] m);
        {clear_btn, start_btn, pause_btn, ext_btn} = m;
        repeat (4) step();
        {clear_btn, start_btn, pause_btn, ext_btn} = 4'b0;
        repeat (3) step();
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc < c && n < 1000) begin
            step();
            n++;
        end
        check("reach_cycle", cyc, c);
    endtask

    task automatic wait_done(input int lim, output int at);
        int n = 0;
        while (!done && n < lim) begin
            step();
            n++;
        end
        at = cyc;
        check("done_reached", done, 1);
    endtask

    task automatic wait_downs(input int k, input int lim);
        int n = 0;
        while (dq.size() < k && n < lim) begin
            step();
            n++;
        end
        check("downs_reached", dq.size(), k);
    endtask

    task automatic clrq();
        lq.delete();
        dq.delete();
        uq.delete();
        rq.delete();
    endtask

    initial begin
        int t0;
        int l;
        int at;
        int d;
        int q;

        rst = 1'b1;
        {clear_btn, start_btn, pause_btn, ext_btn} = 4'b0;
        preset = '0;
        period = '0;
        repeat (2) step();

        // 1: reset state
        check("rst_cnt_rst", cnt_rst, 0);
        check("rst_cnt_load", cnt_load, 0);
        check("rst_cnt_in", cnt_in, 0);
        check("rst_cnt_up", cnt_up, 0);
        check("rst_cnt_down", cnt_down, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", int'(dut.state), int'(IDLE));
        rst = 1'b0;
        step();

        // 2: preset 5, period 4
        preset = 4'd5;
        period = 16'd4;
        clrq();
        t0 = cyc;
        l = t0 + 4;
        press(4'b0100);
        check("t2_load_cnt", lq.size(), 1);
        check("t2_load_cyc", qat(lq, 0), l);
        check("t2_cnt_in", cnt_in, 5);
        wait_done(200, at);
        check("t2_down_cnt", dq.size(), 5);
        check("t2_down0", qat(dq, 0), l + 5);
        check("t2_down_span", qat(dq, 4) - qat(dq, 0), 16);
        check("t2_done_cyc", at, l + 23);
        check("t2_cnt", cnt, 0);
        check("t2_busy", busy, 0);

        // 3: period 0 behaves as 2
        preset = 4'd3;
        period = 16'd0;
        clrq();
        t0 = cyc;
        l = t0 + 4;
        press(4'b0100);
        wait_done(100, at);
        check("t3_down_cnt", dq.size(), 3);
        check("t3_down0", qat(dq, 0), l + 3);
        check("t3_gap1", qat(dq, 1) - qat(dq, 0), 2);
        check("t3_gap2", qat(dq, 2) - qat(dq, 1), 2);
        check("t3_done_cyc", at, l + 9);

        // 4: pause with prescaler at 1, then resume
        preset = 4'd5;
        period = 16'd4;
        clrq();
        press(4'b0100);
        wait_downs(1, 50);
        d = qat(dq, 0);
        wait_cyc(d + 3);
        press(4'b0010);
        repeat (3) step();
        check("t4_paused_downs", dq.size(), 2);
        check("t4_down1", qat(dq, 1), d + 4);
        check("t4_paused_busy", busy, 1);
        check("t4_state", int'(dut.state), int'(PAUSED));
        q = cyc;
        press(4'b0010);
        wait_downs(3, 50);
        check("t4_resume_down", qat(dq, 2), q + 6);
        wait_done(100, at);
        check("t4_down_total", dq.size(), 5);

        // 5: clear and start in the same cycle
        preset = 4'd9;
        period = 16'd50;
        press(4'b0100);
        check("t5_loaded", cnt, 9);
        clrq();
        t0 = cyc;
        press(4'b1100);
        check("t5_rst_cnt", rq.size(), 1);
        check("t5_rst_cyc", qat(rq, 0), t0 + 4);
        check("t5_no_load", lq.size(), 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_cnt", cnt, 0);
        check("t5_state", int'(dut.state), int'(IDLE));

        // 6a: ext saturates at 15
        preset = 4'd15;
        period = 16'd100;
        press(4'b0100);
        clrq();
        press(4'b0001);
        check("t6_sat_up", uq.size(), 0);
        check("t6_sat_cnt", cnt, 15);
        check("t6_sat_busy", busy, 1);

        // 6b: ext lands on the tick cycle
        preset = 4'd7;
        period = 16'd8;
        clrq();
        t0 = cyc;
        l = t0 + 4;
        press(4'b0100);
        wait_cyc(l + 5);
        press(4'b0001);
        wait_downs(1, 60);
        check("t6_coll_up", uq.size(), 0);
        check("t6_coll_down", qat(dq, 0), l + 17);
        check("t6_coll_cnt", cnt, 7);

        // 6c: plain ext mid-period
        d = qat(dq, 0);
        press(4'b0001);
        wait_downs(2, 60);
        check("t6_up_cnt", uq.size(), 1);
        check("t6_up_cyc", qat(uq, 0), d + 4);
        check("t6_down_next", qat(dq, 1), d + 8);
        check("t6_cnt_after", cnt, 7);

        check("one_hot_outputs", multi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
